ibus_mem_responder: RTL and testbench
=====================================

IBUS_MEM_RESPONDER -- requirements
Module: ibus_mem_responder

Interface
REQ-001 SHALL have parameter BASE_ADR, default 32'h10000, byte address of word 0.
REQ-002 SHALL have parameter SIZE, default 4096, memory size in bytes (power of two, >=16).
REQ-003 SHALL have parameter LATENCY, default 2, request-accept to response-ready delay in cycles (1..4).
REQ-004 SHALL have parameter DEPTH, default 4, max outstanding requests (power of two, 2..8).
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port req_valid  input  1  fetch request present.
REQ-008 SHALL have port req_ready  output  1  request accepted this cycle if req_valid.
REQ-009 SHALL have port req_adr  input  32  fetch byte address.
REQ-010 SHALL have port resp_valid  output  1  response present.
REQ-011 SHALL have port resp_ready  input  1  initiator takes response.
REQ-012 SHALL have port resp_data  output  32  instruction word.
REQ-013 SHALL have port resp_status  output  1  0 = OK, 1 = access error.
REQ-014 SHALL have port flush  input  1  discard all outstanding requests/responses.
REQ-015 SHALL have port load_we  input  1  backdoor word write enable.
REQ-016 SHALL have port load_adr  input  32  backdoor byte address.
REQ-017 SHALL have port load_data  input  32  backdoor write data.

Function
REQ-018 SHALL accept a request on any cycle where req_valid && req_ready.
REQ-019 SHALL drive req_ready = 1 iff outstanding count (in flight + queued) < DEPTH and flush = 0.
REQ-020 SHALL present the response for a request accepted at cycle T no earlier than cycle T+LATENCY.
REQ-021 SHALL return responses strictly in acceptance order.
REQ-022 SHALL hold resp_valid, resp_data, resp_status stable until resp_valid && resp_ready.
REQ-023 SHALL decrement outstanding count on each resp handshake; accept and handshake in the same cycle leave count unchanged.
REQ-024 SHALL flag resp_status = 1 and resp_data = 0 when req_adr < BASE_ADR, req_adr >= BASE_ADR+SIZE, or req_adr[1:0] != 0.
REQ-025 SHALL return mem[(req_adr-BASE_ADR)>>2] with status 0 otherwise, sampled at accept.
REQ-026 SHALL, on flush = 1, drop all in-flight and queued entries next cycle, deassert resp_valid, ignore req_valid that cycle.
REQ-027 SHALL, on load_we with in-range aligned load_adr, write the word at clock edge; out-of-range loads ignored.
REQ-028 SHALL, for load_we and an accepted request to the same word in one cycle, return the old word.
REQ-029 SHALL wrap FIFO read/write pointers modulo DEPTH with no lost or duplicated entry.

Reset
REQ-030 SHALL, with rst_n = 0 at a clock edge, clear outstanding count, pipeline valids and FIFO pointers.
REQ-031 SHALL drive req_ready = 0, resp_valid = 0, resp_data = 0, resp_status = 0 during reset.
REQ-032 SHALL preserve memory contents across reset; reset mid-transaction discards it without response.

Structure
REQ-033 SHALL place the status encoding enum (OK, ERR) and the response struct {data, status} in cpu_parameters.
REQ-034 SHALL instantiate one sub-module, resp_fifo, parameterized by DEPTH, holding response structs.
REQ-035 SHALL implement LATENCY as a valid-tagged shift pipeline feeding resp_fifo.

Verification
REQ-036 SHALL cover: load 0x00000013 at 0x10000, request 0x10000, resp_ready = 1 -> resp_valid at T+2, data 0x00000013, status 0.
REQ-037 SHALL cover: resp_ready = 0, stream requests -> exactly 4 accepted, req_ready = 0, then 4 in-order responses when resp_ready = 1.
REQ-038 SHALL cover: requests 0x0FFFC, 0x11000, 0x10002 -> three responses status 1, data 0.
REQ-039 SHALL cover: 3 outstanding, flush pulse -> resp_valid = 0 next cycle, no stale responses afterward, new request answered normally.
REQ-040 SHALL cover: rst_n low mid-stream 1 cycle -> outputs 0, count 0, previously loaded word still returned after reset.
REQ-041 SHALL cover: back-to-back accept every cycle with resp_ready = 1 -> one response per cycle, throughput 1.

Source files
------------

// File: rtl/cpu_parameters.sv
// Shared types for the instruction-bus memory responder: response status, response record and
// the address legality rule used by both the fetch and backdoor-load paths.
package cpu_parameters;

  typedef enum logic {
    StatusOk  = 1'b0,
    StatusErr = 1'b1
  } status_e;

  typedef struct packed {
    logic [31:0] data;
    status_e     status;
  } resp_t;

  // True when adr is word-aligned and falls inside [base, base + size).
  // The offset is computed one bit wider so base + size may reach 2^32 without wrapping.
  function automatic logic adr_ok(input logic [31:0] adr, input logic [31:0] base,
                                  input logic [32:0] size);
    logic [32:0] off;
    off = {1'b0, adr} - {1'b0, base};
    return (adr >= base) && (off < size) && (adr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/resp_fifo.sv
// Response queue between the latency pipeline and the initiator. The top never pushes more than
// DEPTH entries in total, so there is no full flag; pointers wrap naturally at a power of two.
module resp_fifo
  import cpu_parameters::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  flush,
  input  logic  push,
  input  resp_t push_data,
  input  logic  pop,
  output resp_t head,
  output logic  not_empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  resp_t          mem_q [DEPTH];
  logic [PW-1:0]  wptr_q;
  logic [PW-1:0]  rptr_q;
  logic [PW:0]    cnt_q;

  // Entry storage; contents need no reset because occupancy is tracked by cnt_q.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Head entry and occupancy flag.
  always_comb begin
    head      = mem_q[rptr_q];
    not_empty = (cnt_q != '0);
  end

endmodule

// File: rtl/ibus_mem_responder.sv
// Instruction-fetch memory responder: word memory with a backdoor loader, a fixed-latency
// valid-tagged pipeline and an in-order response queue with flow control and flush.
module ibus_mem_responder
  import cpu_parameters::*;
#(
  parameter logic [31:0] BASE_ADR = 32'h10000,
  parameter int unsigned SIZE     = 4096,
  parameter int unsigned LATENCY  = 2,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_adr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_status,
  input  logic        flush,
  input  logic        load_we,
  input  logic [31:0] load_adr,
  input  logic [31:0] load_data
);

  localparam int unsigned WORDS = SIZE / 4;
  localparam int unsigned AW    = $clog2(WORDS);
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic [31:0]   mem_q [WORDS];
  logic [CW-1:0] cnt_q;
  logic [AW-1:0] req_idx;
  logic [AW-1:0] load_idx;
  logic          accept;
  logic          resp_hs;
  logic          load_ok;
  logic          push;
  logic          fifo_valid;
  resp_t         rd_resp;
  resp_t         push_resp;
  resp_t         head_resp;

  // Request acceptance, address decode and response lookup at accept time.
  always_comb begin
    req_idx   = AW'((req_adr - BASE_ADR) >> 2);
    load_idx  = AW'((load_adr - BASE_ADR) >> 2);
    load_ok   = adr_ok(load_adr, BASE_ADR, 33'(SIZE));
    req_ready = rst_n && !flush && (cnt_q < CW'(DEPTH));
    accept    = req_valid && req_ready;
    resp_hs   = resp_valid && resp_ready;
    rd_resp   = '{data: '0, status: StatusErr};
    if (adr_ok(req_adr, BASE_ADR, 33'(SIZE))) begin
      rd_resp = '{data: mem_q[req_idx], status: StatusOk};
    end
  end

  // Outstanding requests (pipeline plus queue); bounds acceptance so the queue cannot overflow.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      cnt_q <= '0;
    end else begin
      unique case ({accept, resp_hs})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Backdoor word write; memory survives reset. A same-cycle fetch sees the old word.
  always_ff @(posedge clk) begin
    if (load_we && load_ok) begin
      mem_q[load_idx] <= load_data;
    end
  end

  // LATENCY-1 register stages; the queue write supplies the final cycle of delay.
  if (LATENCY == 1) begin : g_direct
    assign push      = accept;
    assign push_resp = rd_resp;
  end else begin : g_pipe
    logic [LATENCY-2:0] vld_q;
    resp_t              dat_q [LATENCY-1];

    // Valid tags are cleared by reset and flush so dropped entries never reach the queue.
    always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= accept;
        for (int i = 1; i < int'(LATENCY) - 1; i++) begin
          vld_q[i] <= vld_q[i-1];
        end
      end
    end

    // Payload shift; qualified only by the valid tags.
    always_ff @(posedge clk) begin
      dat_q[0] <= rd_resp;
      for (int i = 1; i < int'(LATENCY) - 1; i++) begin
        dat_q[i] <= dat_q[i-1];
      end
    end

    assign push      = vld_q[LATENCY-2];
    assign push_resp = dat_q[LATENCY-2];
  end

  resp_fifo #(
    .DEPTH (DEPTH)
  ) u_resp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (push),
    .push_data (push_resp),
    .pop       (resp_hs),
    .head      (head_resp),
    .not_empty (fifo_valid)
  );

  // Response outputs are forced to zero while in reset or when nothing is presented.
  always_comb begin
    resp_valid  = rst_n && fifo_valid;
    resp_data   = resp_valid ? head_resp.data : 32'h0;
    resp_status = resp_valid ? head_resp.status : 1'b0;
  end

endmodule

// File: tb/tb_ibus_mem_responder.sv
// Randomized and directed bench for ibus_mem_responder against a queue-based reference model.
module tb_ibus_mem_responder;

  localparam logic [31:0] BASE    = 32'h10000;
  localparam int          SIZE    = 4096;
  localparam int          LATENCY = 2;
  localparam int          DEPTH   = 4;
  localparam int          WORDS   = SIZE / 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_adr = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic        resp_status;
  logic        flush = 1'b0;
  logic        load_we = 1'b0;
  logic [31:0] load_adr = '0;
  logic [31:0] load_data = '0;

  ibus_mem_responder #(
    .BASE_ADR (BASE),
    .SIZE     (SIZE),
    .LATENCY  (LATENCY),
    .DEPTH    (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_adr     (req_adr),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_data   (resp_data),
    .resp_status (resp_status),
    .flush       (flush),
    .load_we     (load_we),
    .load_adr    (load_adr),
    .load_data   (load_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        status;
    int          rdy;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mem_m [WORDS];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          n_acc = 0;
  int          n_resp = 0;
  int          n_err = 0;
  logic        obs_valid;
  logic        obs_ready;
  logic [31:0] last_hs_data;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit m_ok(input logic [31:0] a);
    longint la;
    la = longint'(a);
    return la >= longint'(BASE) && la < longint'(BASE) + SIZE && a[1:0] == 2'b00;
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  // One clock: check outputs against the model mid-cycle, then advance the model over the edge.
  task automatic cycle();
    logic exp_ready;
    logic exp_valid;
    exp_t e;
    @(negedge clk);
    exp_ready = rst_n && !flush && (q.size() < DEPTH);
    exp_valid = rst_n && (q.size() > 0) && (q.size() > 0 ? q[0].rdy <= cyc : 1'b0);
    obs_valid = resp_valid;
    obs_ready = req_ready;
    check_eq("req_ready", {31'b0, req_ready}, {31'b0, exp_ready});
    check_eq("resp_valid", {31'b0, resp_valid}, {31'b0, exp_valid});
    if (exp_valid) begin
      check_eq("resp_data", resp_data, q[0].data);
      check_eq("resp_status", {31'b0, resp_status}, {31'b0, q[0].status});
    end else if (!rst_n) begin
      check_eq("rst_data", resp_data, 32'h0);
      check_eq("rst_status", {31'b0, resp_status}, 32'h0);
    end
    if (!rst_n || flush) begin
      q.delete();
    end else begin
      if (exp_valid && resp_ready) begin
        last_hs_data = resp_data;
        if (resp_status) n_err++;
        void'(q.pop_front());
        n_resp++;
      end
      if (req_valid && exp_ready) begin
        e.status = !m_ok(req_adr);
        e.data   = m_ok(req_adr) ? mem_m[m_idx(req_adr)] : 32'h0;
        e.rdy    = cyc + LATENCY;
        q.push_back(e);
        n_acc++;
      end
    end
    if (load_we && m_ok(load_adr)) mem_m[m_idx(load_adr)] = load_data;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    load_we   = 1'b0;
    flush     = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  function automatic logic [31:0] rand_in_range();
    return BASE + ($urandom_range(0, WORDS - 1) * 4);
  endfunction

  function automatic logic [31:0] rand_adr();
    int k;
    k = $urandom_range(0, 9);
    case (k)
      0:       return BASE - 4;
      1:       return BASE + SIZE;
      2:       return BASE + SIZE - 4;
      3:       return BASE + 32'd1 + ($urandom_range(0, WORDS - 1) * 4);
      4:       return 32'hFFFF_FFFC;
      default: return rand_in_range();
    endcase
  endfunction

  initial begin
    int a0;
    int r0;
    int e0;
    int t0;
    int t_first;

    // Reset state
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    check_eq("reset_req_ready", {31'b0, obs_ready}, 32'h0);
    check_eq("reset_resp_valid", {31'b0, obs_valid}, 32'h0);
    rst_n = 1'b1;
    cycle();

    // Preload every word; word 0 holds the NOP used by the directed cases
    load_we = 1'b1;
    for (int i = 0; i < WORDS; i++) begin
      load_adr  = BASE + i * 4;
      load_data = (i == 0) ? 32'h0000_0013 : $urandom;
      cycle();
    end
    // Misaligned and out-of-range loads must not disturb memory
    load_adr = BASE + 32'd5;        load_data = 32'hDEAD_0001; cycle();
    load_adr = BASE + SIZE;         load_data = 32'hDEAD_0002; cycle();
    load_adr = BASE - 4;            load_data = 32'hDEAD_0003; cycle();
    idle(2);

    // Single fetch: response exactly LATENCY cycles after accept
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_adr    = BASE;
    t0 = cyc;
    r0 = n_resp;
    cycle();
    req_valid = 1'b0;
    t_first = -1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (obs_valid && t_first < 0) t_first = cyc - 1;
    end
    check_eq("first_latency", t_first - t0, LATENCY);
    check_eq("first_data", last_hs_data, 32'h0000_0013);
    check_eq("first_count", n_resp - r0, 1);

    // Backpressure: exactly DEPTH accepted, then drained in order
    resp_ready = 1'b0;
    a0 = n_acc;
    req_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req_adr = rand_in_range();
      cycle();
    end
    check_eq("bp_accepted", n_acc - a0, DEPTH);
    check_eq("bp_ready_low", {31'b0, obs_ready}, 32'h0);
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    r0 = n_resp;
    idle(8);
    check_eq("bp_drained", n_resp - r0, DEPTH);

    // Access errors at both range edges and misaligned
    e0 = n_err;
    req_valid = 1'b1;
    req_adr = 32'h0000_FFFC; cycle();
    req_adr = 32'h0001_1000; cycle();
    req_adr = 32'h0001_0002; cycle();
    idle(6);
    check_eq("err_count", n_err - e0, 3);

    // Flush with three outstanding
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_adr = rand_in_range();
      cycle();
    end
    req_valid = 1'b0;
    cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    resp_ready = 1'b1;
    r0 = n_resp;
    cycle();
    check_eq("flush_valid_low", {31'b0, obs_valid}, 32'h0);
    idle(6);
    check_eq("flush_no_stale", n_resp - r0, 0);
    req_valid = 1'b1;
    req_adr   = BASE + 32'd20;
    cycle();
    idle(5);
    check_eq("flush_new_count", n_resp - r0, 1);
    check_eq("flush_new_data", last_hs_data, mem_m[5]);

    // Reset in the middle of a stream
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_adr = rand_in_range();
      cycle();
    end
    rst_n = 1'b0;
    cycle();
    check_eq("midrst_ready", {31'b0, obs_ready}, 32'h0);
    check_eq("midrst_valid", {31'b0, obs_valid}, 32'h0);
    rst_n = 1'b1;
    r0 = n_resp;
    idle(6);
    check_eq("midrst_discard", n_resp - r0, 0);
    req_valid = 1'b1;
    req_adr   = BASE;
    cycle();
    idle(5);
    check_eq("midrst_mem_kept", last_hs_data, 32'h0000_0013);

    // Back-to-back: one accept and one response per cycle
    a0 = n_acc;
    r0 = n_resp;
    req_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      req_adr = rand_in_range();
      cycle();
    end
    check_eq("b2b_accepts", n_acc - a0, 30);
    check_eq("b2b_resps", n_resp - r0, 30 - LATENCY);
    idle(6);

    // Random traffic with loads, flushes and occasional reset
    for (int i = 0; i < 3000; i++) begin
      req_valid  = ($urandom_range(0, 3) != 0);
      req_adr    = rand_adr();
      resp_ready = ($urandom_range(0, 9) < 7);
      load_we    = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 2))
        0:       load_adr = req_adr;
        1:       load_adr = rand_in_range();
        default: load_adr = rand_adr();
      endcase
      load_data = $urandom;
      flush     = ($urandom_range(0, 49) == 0);
      rst_n     = ($urandom_range(0, 199) != 0);
      cycle();
    end
    rst_n      = 1'b1;
    resp_ready = 1'b1;
    idle(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
